// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use/branch/jump/mem-wait hazards drive stall, flush and post-stall/post-flush controls.
// Latency: stall/flush/hold are combinational; ifid_poststall/ifid_postflush and statistics update one cycle later.
module hazard_ctrl #(
    parameter int REG_AW   = 3,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              id_jump,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    input  logic              clr_stats,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_poststall,
    output logic              ifid_postflush,
    output logic              idex_flush,
    output logic              pipe_hold,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;

    state_t           state_q, state_d;
    logic             squash_q;
    logic             poststall_q;
    logic [WW-1:0]    wait_cnt_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic load_use;
    logic stall;
    logic flush_acc;

    always_comb begin
        load_use = ex_memread && (ex_rd != '0) &&
                   ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
        stall     = mem_busy | (load_use & ~ex_branch_taken);
        // A jump is masked by a load-use stall; ID re-presents it on the next cycle.
        flush_acc = ~mem_busy & (ex_branch_taken | (id_jump & ~load_use));
        if (mem_busy) begin
            state_d = MEMWAIT;
        end else if (flush_acc) begin
            state_d = FLUSH;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            squash_q    <= 1'b1;
            poststall_q <= 1'b0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            squash_q    <= 1'b0;
            poststall_q <= stall;

            if (!mem_busy) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WW'(MAX_WAIT)) begin
                wait_cnt_q <= wait_cnt_q + WW'(1);
            end

            // Fires on the first busy cycle beyond the tolerated MAX_WAIT run.
            if (mem_busy && (wait_cnt_q == WW'(MAX_WAIT))) begin
                timeout_q <= 1'b1;
            end

            if (clr_stats) begin
                stall_cnt_q <= '0;
                flush_cnt_q <= '0;
            end else begin
                if (stall && (stall_cnt_q != '1)) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
                if (flush_acc && (flush_cnt_q != '1)) begin
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // The reset-time squash covers the first fetch, which the FSM state alone cannot express.
    assign ifid_postflush = (state_q == FLUSH) | squash_q;
    assign ifid_poststall = poststall_q;
    assign pc_stall       = stall;
    assign ifid_stall     = stall;
    assign idex_flush     = ~mem_busy & (ex_branch_taken | load_use);
    assign pipe_hold      = mem_busy;
    assign mem_timeout    = timeout_q;
    assign stall_count    = stall_cnt_q;
    assign flush_count    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus randomized traffic against a cycle-level reference model.
module tb_hazard_ctrl;
    localparam int REG_AW   = 3;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 6;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, id_use_rs, id_use_rt, ex_memread, id_jump, ex_branch_taken, mem_busy, clr_stats;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rd;
    logic pc_stall, ifid_stall, ifid_poststall, ifid_postflush, idex_flush, pipe_hold, mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .ex_memread(ex_memread), .ex_rd(ex_rd), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .clr_stats(clr_stats),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_poststall(ifid_poststall),
        .ifid_postflush(ifid_postflush), .idex_flush(idex_flush), .pipe_hold(pipe_hold),
        .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, all plain integers.
    int m_postflush, m_poststall, m_busy_run, m_timeout, m_stalls, m_flushes;
    int e_lu, e_stall, e_flush, e_accept;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic idle();
        rst = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; ex_memread = 0;
        ex_rd = 0; id_jump = 0; ex_branch_taken = 0; mem_busy = 0; clr_stats = 0;
    endtask

    task automatic load_use(input int r);
        ex_memread = 1; ex_rd = REG_AW'(r); id_rs = REG_AW'(r); id_use_rs = 1;
    endtask

    task automatic tick();
        @(negedge clk);
        e_lu = (ex_memread && ex_rd != 0 &&
                ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd))) ? 1 : 0;
        e_stall  = (mem_busy || (e_lu && !ex_branch_taken)) ? 1 : 0;
        e_flush  = (!mem_busy && (ex_branch_taken || e_lu)) ? 1 : 0;
        e_accept = (!mem_busy && (ex_branch_taken || (id_jump && !e_lu))) ? 1 : 0;
        chk("pipe_hold", int'(pipe_hold), int'(mem_busy));
        chk("pc_stall", int'(pc_stall), e_stall);
        chk("ifid_stall", int'(ifid_stall), e_stall);
        chk("idex_flush", int'(idex_flush), e_flush);
        chk("ifid_poststall", int'(ifid_poststall), m_poststall);
        chk("ifid_postflush", int'(ifid_postflush), m_postflush);
        chk("mem_timeout", int'(mem_timeout), m_timeout);
        chk("stall_count", int'(stall_count), m_stalls);
        chk("flush_count", int'(flush_count), m_flushes);
        if (rst) begin
            m_postflush = 1; m_poststall = 0; m_busy_run = 0;
            m_timeout = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            m_postflush = e_accept;
            m_poststall = e_stall;
            if (mem_busy) begin
                if (m_busy_run >= MAX_WAIT) m_timeout = 1;
                m_busy_run++;
            end else begin
                m_busy_run = 0;
            end
            if (clr_stats) begin
                m_stalls = 0; m_flushes = 0;
            end else begin
                if (e_stall && m_stalls < CNT_MAX) m_stalls++;
                if (e_accept && m_flushes < CNT_MAX) m_flushes++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int burst;
        m_postflush = 1; m_poststall = 0; m_busy_run = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
        idle();
        rst = 1;
        tick(); tick();
        chk("rst_stall_count", int'(stall_count), 0);
        rst = 0;
        tick();
        chk("rst_first_postflush", int'(ifid_postflush), 0);
        tick();

        // Load-use with a real dependency, then the same pattern on r0.
        load_use(3); tick();
        chk("lu_poststall", int'(ifid_poststall), 1);
        chk("lu_stall_count", int'(stall_count), 1);
        idle(); tick();
        load_use(0); tick();
        idle(); tick();

        // Taken branch overrides a coincident load-use.
        load_use(5); ex_branch_taken = 1; tick();
        chk("br_postflush", int'(ifid_postflush), 1);
        chk("br_flush_count", int'(flush_count), 1);
        idle(); tick();

        // Jump masked by load-use, accepted once the dependency clears.
        load_use(2); id_jump = 1; tick();
        chk("jmp_masked_postflush", int'(ifid_postflush), 0);
        idle(); id_jump = 1; tick();
        chk("jmp_postflush", int'(ifid_postflush), 1);
        idle(); tick();

        // Memory wait holding back a taken branch.
        clr_stats = 1; tick();
        idle(); mem_busy = 1; ex_branch_taken = 1;
        repeat (5) tick();
        mem_busy = 0; tick();
        chk("mw_stall_count", int'(stall_count), 5);
        chk("mw_postflush", int'(ifid_postflush), 1);
        idle(); tick();

        // Watchdog: exactly MAX_WAIT busy cycles is tolerated, a longer run is not.
        mem_busy = 1; repeat (MAX_WAIT) tick();
        mem_busy = 0; tick();
        chk("wd_tolerated", int'(mem_timeout), 0);
        mem_busy = 1; repeat (20) tick();
        mem_busy = 0; tick(); tick();
        chk("wd_sticky", int'(mem_timeout), 1);

        // Counter saturation and clear.
        load_use(4); repeat (CNT_MAX + 5) tick();
        chk("sat_stall_count", int'(stall_count), CNT_MAX);
        idle(); clr_stats = 1; load_use(4); tick();
        chk("clr_stall_count", int'(stall_count), 0);
        idle(); rst = 1; tick();
        chk("rst_timeout", int'(mem_timeout), 0);

        // Randomized traffic with occasional long memory waits, clears and resets.
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            clr_stats = ($urandom_range(0, 49) == 0);
            id_rs = REG_AW'($urandom); id_rt = REG_AW'($urandom); ex_rd = REG_AW'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            ex_memread = ($urandom_range(0, 2) == 0);
            id_jump = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            if (burst == 0 && $urandom_range(0, 14) == 0) burst = $urandom_range(1, 20);
            mem_busy = (burst > 0);
            if (burst > 0) burst--;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
